muldiv_unit: RTL

MULDIV_UNIT -- requirements
Module: muldiv_unit

---
 rtl/muldiv_pkg.sv | 35 +++
 rtl/muldiv_negate.sv | 19 +
 rtl/muldiv_unit.sv | 239 +++++++++++++++++++++++
 3 files changed

// File: rtl/muldiv_pkg.sv
// ----------------------------------------------------------------------------
// muldiv_pkg
// Shared definitions for the iterative multiply/divide unit and its
// neighbours (decode stage, HI/LO forwarding).
//   op_e          : operation encoding carried on the 2-bit op port
//   state_e       : sequencer states of muldiv_unit
//   DEFAULT_WIDTH : default operand/result width in bits
// Helpers classify an operation as divide and/or signed.
// ----------------------------------------------------------------------------
package muldiv_pkg;

  localparam int DEFAULT_WIDTH = 32;

  typedef enum logic [1:0] {
    OP_MULT  = 2'd0,
    OP_MULTU = 2'd1,
    OP_DIV   = 2'd2,
    OP_DIVU  = 2'd3
  } op_e;

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_CALC = 2'd1,
    S_DONE = 2'd2
  } state_e;

  function automatic logic op_is_div(input op_e op);
    return (op == OP_DIV) || (op == OP_DIVU);
  endfunction

  function automatic logic op_is_signed(input op_e op);
    return (op == OP_MULT) || (op == OP_DIV);
  endfunction

endpackage

// File: rtl/muldiv_negate.sv
// ----------------------------------------------------------------------------
// muldiv_negate
// Conditional two's-complement: val_o = neg_i ? -val_i : val_i.
// Used both to take operand magnitudes and to apply the result sign.
//   neg_i : negate when high
//   val_i : W-bit input value
//   val_o : W-bit output value
// ----------------------------------------------------------------------------
module muldiv_negate #(
  parameter int W = 32
) (
  input  logic         neg_i,
  input  logic [W-1:0] val_i,
  output logic [W-1:0] val_o
);

  assign val_o = neg_i ? (~val_i + W'(1)) : val_i;

endmodule

// File: rtl/muldiv_unit.sv
// ----------------------------------------------------------------------------
// muldiv_unit
// Iterative radix-2 multiply/divide unit. Multiplication is shift-add and
// division is restoring, both on operand magnitudes; the result sign is
// fixed up on the edge that enters DONE. Divide by zero skips CALC.
//   clock     : rising-edge clock
//   reset     : asynchronous active-high reset
//   start     : request, sampled only in IDLE
//   op        : 0 MULT, 1 MULTU, 2 DIV, 3 DIVU
//   operand_a : multiplicand / dividend
//   operand_b : multiplier / divisor
//   cancel    : abort any operation (wins over start)
//   busy      : high in every non-IDLE state
//   done      : one-cycle pulse, hi/lo valid in this cycle
//   hi, lo    : high product / remainder, low product / quotient
// ----------------------------------------------------------------------------
module muldiv_unit
  import muldiv_pkg::*;
#(
  parameter int WIDTH = DEFAULT_WIDTH
) (
  input  logic             clock,
  input  logic             reset,
  input  logic             start,
  input  logic [1:0]       op,
  input  logic [WIDTH-1:0] operand_a,
  input  logic [WIDTH-1:0] operand_b,
  input  logic             cancel,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] hi,
  output logic [WIDTH-1:0] lo
);

  localparam int               CNT_W     = $clog2(WIDTH) + 1;
  localparam logic [CNT_W-1:0] LAST_ITER = CNT_W'(WIDTH - 1);

  state_e           state_q, state_d;
  op_e              op_q, op_d;
  logic [WIDTH-1:0] acc_hi_q, acc_hi_d;   // partial product high / remainder
  logic [WIDTH-1:0] acc_lo_q, acc_lo_d;   // multiplier->product low / dividend->quotient
  logic [WIDTH-1:0] opnd_q, opnd_d;       // multiplicand or divisor magnitude
  logic             neg_lo_q, neg_lo_d;   // negate product, or quotient
  logic             neg_hi_q, neg_hi_d;   // negate remainder
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [WIDTH-1:0] hi_q, hi_d;
  logic [WIDTH-1:0] lo_q, lo_d;

  // --------------------------------------------------------------------------
  // Request decode and operand magnitudes
  // --------------------------------------------------------------------------
  op_e              op_in;
  logic             in_signed;
  logic             in_div;
  logic             a_neg;
  logic             b_neg;
  logic [WIDTH-1:0] a_mag;
  logic [WIDTH-1:0] b_mag;

  assign op_in     = op_e'(op);
  assign in_signed = op_is_signed(op_in);
  assign in_div    = op_is_div(op_in);
  assign a_neg     = in_signed & operand_a[WIDTH-1];
  assign b_neg     = in_signed & operand_b[WIDTH-1];

  muldiv_negate #(.W(WIDTH)) u_neg_a (
    .neg_i (a_neg),
    .val_i (operand_a),
    .val_o (a_mag)
  );

  muldiv_negate #(.W(WIDTH)) u_neg_b (
    .neg_i (b_neg),
    .val_i (operand_b),
    .val_o (b_mag)
  );

  // --------------------------------------------------------------------------
  // One radix-2 step
  // --------------------------------------------------------------------------
  logic             div_q;
  logic [WIDTH:0]   mul_sum;
  logic [WIDTH:0]   div_shift;
  logic [WIDTH:0]   div_diff;
  logic             q_bit;
  logic [WIDTH-1:0] step_hi;
  logic [WIDTH-1:0] step_lo;

  assign div_q = op_is_div(op_q);

  // Shift-add: add multiplicand when the current multiplier LSB is set, then
  // shift the whole {carry, acc_hi, acc_lo} right by one.
  assign mul_sum = {1'b0, acc_hi_q} + (acc_lo_q[0] ? {1'b0, opnd_q} : '0);

  // Restoring divide: bring in the next dividend bit; a non-negative trial
  // difference (MSB clear) means the divisor fits and the quotient bit is 1.
  assign div_shift = {acc_hi_q, acc_lo_q[WIDTH-1]};
  assign div_diff  = div_shift - {1'b0, opnd_q};
  assign q_bit     = ~div_diff[WIDTH];

  always_comb begin
    if (div_q) begin
      step_hi = q_bit ? div_diff[WIDTH-1:0] : div_shift[WIDTH-1:0];
      step_lo = {acc_lo_q[WIDTH-2:0], q_bit};
    end else begin
      step_hi = mul_sum[WIDTH:1];
      step_lo = {mul_sum[0], acc_lo_q[WIDTH-1:1]};
    end
  end

  // --------------------------------------------------------------------------
  // Sign correction of the final step, applied on the edge into DONE
  // --------------------------------------------------------------------------
  logic [2*WIDTH-1:0] prod_fix;
  logic [WIDTH-1:0]   quo_fix;
  logic [WIDTH-1:0]   rem_fix;
  logic [WIDTH-1:0]   res_hi;
  logic [WIDTH-1:0]   res_lo;

  muldiv_negate #(.W(2 * WIDTH)) u_neg_prod (
    .neg_i (neg_lo_q),
    .val_i ({step_hi, step_lo}),
    .val_o (prod_fix)
  );

  muldiv_negate #(.W(WIDTH)) u_neg_quo (
    .neg_i (neg_lo_q),
    .val_i (step_lo),
    .val_o (quo_fix)
  );

  muldiv_negate #(.W(WIDTH)) u_neg_rem (
    .neg_i (neg_hi_q),
    .val_i (step_hi),
    .val_o (rem_fix)
  );

  assign res_hi = div_q ? rem_fix : prod_fix[2*WIDTH-1:WIDTH];
  assign res_lo = div_q ? quo_fix : prod_fix[WIDTH-1:0];

  // --------------------------------------------------------------------------
  // Next-state and datapath control
  // --------------------------------------------------------------------------
  always_comb begin
    // NOTE: every variable gets a default first so no path leaves one
    // unassigned, which would otherwise infer a latch.
    state_d  = state_q;
    op_d     = op_q;
    acc_hi_d = acc_hi_q;
    acc_lo_d = acc_lo_q;
    opnd_d   = opnd_q;
    neg_lo_d = neg_lo_q;
    neg_hi_d = neg_hi_q;
    cnt_d    = cnt_q;
    hi_d     = hi_q;
    lo_d     = lo_q;

    unique case (state_q)
      S_IDLE: begin
        if (start && !cancel) begin
          op_d     = op_in;
          neg_lo_d = a_neg ^ b_neg;
          neg_hi_d = in_div & a_neg;
          cnt_d    = '0;
          acc_hi_d = '0;
          if (in_div && (operand_b == '0)) begin
            // Divide by zero bypasses CALC and reports a defined result.
            state_d = S_DONE;
            hi_d    = operand_a;
            lo_d    = '1;
          end else begin
            state_d  = S_CALC;
            acc_lo_d = in_div ? a_mag : b_mag;
            opnd_d   = in_div ? b_mag : a_mag;
          end
        end
      end

      S_CALC: begin
        if (cancel) begin
          state_d = S_IDLE;
        end else begin
          acc_hi_d = step_hi;
          acc_lo_d = step_lo;
          cnt_d    = cnt_q + CNT_W'(1);
          if (cnt_q == LAST_ITER) begin
            state_d = S_DONE;
            hi_d    = res_hi;
            lo_d    = res_lo;
          end
        end
      end

      S_DONE: begin
        state_d = S_IDLE;
      end

      default: begin
        state_d = S_IDLE;
      end
    endcase
  end

  // NOTE: sequential state uses non-blocking assignments so every register
  // samples its pre-edge value, independent of statement order.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      // NOTE: the accumulators are reset too, so no operand data from an
      // aborted operation survives reset.
      state_q  <= S_IDLE;
      op_q     <= OP_MULT;
      acc_hi_q <= '0;
      acc_lo_q <= '0;
      opnd_q   <= '0;
      neg_lo_q <= 1'b0;
      neg_hi_q <= 1'b0;
      cnt_q    <= '0;
      hi_q     <= '0;
      lo_q     <= '0;
    end else begin
      state_q  <= state_d;
      op_q     <= op_d;
      acc_hi_q <= acc_hi_d;
      acc_lo_q <= acc_lo_d;
      opnd_q   <= opnd_d;
      neg_lo_q <= neg_lo_d;
      neg_hi_q <= neg_hi_d;
      cnt_q    <= cnt_d;
      hi_q     <= hi_d;
      lo_q     <= lo_d;
    end
  end

  assign busy = (state_q != S_IDLE);
  assign done = (state_q == S_DONE);
  assign hi   = hi_q;
  assign lo   = lo_q;

endmodule
